// File: rtl/shade_pkg.sv
// Shared definitions for the window-shade motor driver: FSM state encoding and
// position-range helpers.
package shade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_SETTLE    = 2'd3
  } state_t;

  localparam int POS_W_DEF = 4;

  // Fully-closed position for a given position width.
  function automatic int pos_max(input int w);
    return (2 ** w) - 1;
  endfunction

endpackage

// File: rtl/shade_step_timer.sv
// Step-period down-counter: holds at STEP_CYCLES-1 while reloaded, counts down while
// enabled and emits a one-cycle tick on the terminal count, reloading itself.
module shade_step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_reload,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] L_RELOAD = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_reload) begin
      r_count <= L_RELOAD;
    end else if (i_enable) begin
      r_count <= (r_count == '0) ? L_RELOAD : (r_count - CW'(1));
    end
  end

  assign o_tick = i_enable && (r_count == '0);

endmodule

// File: rtl/shade_motor_driver.sv
// Window-shade motor driver: steps the tracked position toward the latest requested
// shade degree. Define SHADE_LIMIT_SW_EN to add lim_top/lim_bot end-stop inputs.
//
// state     | meaning
// IDLE      | motors off, position == target, waiting for a request
// MOVE_UP   | motor_up on, one position step per STEP_CYCLES
// MOVE_DOWN | motor_down on, one position step per STEP_CYCLES
// SETTLE    | motors off for one evaluation cycle; decides done / direction
module shade_motor_driver
  import shade_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int POS_W       = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] wshade,
  input  logic             target_valid,
`ifdef SHADE_LIMIT_SW_EN
  input  logic             lim_top,
  input  logic             lim_bot,
`endif
  output logic             motor_up,
  output logic             motor_down,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam logic [POS_W-1:0] L_POS_MAX = POS_W'(pos_max(POS_W));

  state_t           r_state;
  logic [POS_W-1:0] r_target;
  logic [POS_W-1:0] r_position;
  logic             r_motor_up;
  logic             r_motor_down;
  logic             r_busy;
  logic             r_done;

  logic             w_moving;
  logic             w_tick;
  logic             w_lim_top;
  logic             w_lim_bot;
  logic [POS_W-1:0] w_tgt;
  logic [POS_W-1:0] w_pos_up;
  logic [POS_W-1:0] w_pos_dn;

`ifdef SHADE_LIMIT_SW_EN
  assign w_lim_top = lim_top;
  assign w_lim_bot = lim_bot;
`else
  assign w_lim_top = 1'b0;
  assign w_lim_bot = 1'b0;
`endif

  assign w_moving = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
  // A request arriving this cycle already decides direction while moving.
  assign w_tgt    = target_valid ? wshade : r_target;
  assign w_pos_up = r_position + POS_W'(1);
  assign w_pos_dn = r_position - POS_W'(1);

  shade_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .i_reload (!w_moving),
    .i_enable (w_moving),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_target     <= '0;
      r_position   <= '0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (target_valid) r_target <= wshade;
      case (r_state)
        ST_IDLE: begin
          if (target_valid) begin
            r_state <= ST_SETTLE;
            r_busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!target_valid) begin
            if (r_position == r_target) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_target > r_position) begin
              r_state    <= ST_MOVE_UP;
              r_motor_up <= 1'b1;
            end else begin
              r_state      <= ST_MOVE_DOWN;
              r_motor_down <= 1'b1;
            end
          end
        end
        ST_MOVE_UP: begin
          if (w_lim_top) begin
            r_position <= L_POS_MAX;
            r_target   <= L_POS_MAX;
            r_state    <= ST_SETTLE;
            r_motor_up <= 1'b0;
          end else if (w_tgt <= r_position) begin
            r_state    <= ST_SETTLE;
            r_motor_up <= 1'b0;
          end else if (w_tick) begin
            r_position <= w_pos_up;
            if (w_pos_up == w_tgt) begin
              r_state    <= ST_SETTLE;
              r_motor_up <= 1'b0;
            end
          end
        end
        ST_MOVE_DOWN: begin
          if (w_lim_bot) begin
            r_position   <= '0;
            r_target     <= '0;
            r_state      <= ST_SETTLE;
            r_motor_down <= 1'b0;
          end else if (w_tgt >= r_position) begin
            r_state      <= ST_SETTLE;
            r_motor_down <= 1'b0;
          end else if (w_tick) begin
            r_position <= w_pos_dn;
            if (w_pos_dn == w_tgt) begin
              r_state      <= ST_SETTLE;
              r_motor_down <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_motor_up   <= 1'b0;
          r_motor_down <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign motor_up   = r_motor_up;
  assign motor_down = r_motor_down;
  assign position   = r_position;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_shade_motor_driver.sv
// Self-checking bench for shade_motor_driver (STEP_CYCLES=4, POS_W=4): table of moves
// with a done-event scoreboard, plus hand sequences for retarget, reset and limit cases.
module tb_shade_motor_driver;

  localparam int BUDGET = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       target_valid = 1'b0;
  logic [3:0] wshade = 4'd0;
  logic       motor_up;
  logic       motor_down;
  logic [3:0] position;
  logic       busy;
  logic       done;
`ifdef SHADE_LIMIT_SW_EN
  logic       lim_top = 1'b0;
  logic       lim_bot = 1'b0;
`endif

  typedef struct {
    int pos;
    int lat;
    int up;
    int dn;
  } exp_t;

  typedef struct {
    logic [3:0] ws;
    int         lat;
    int         up;
    int         dn;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_position = 0;

  shade_motor_driver #(
    .STEP_CYCLES(4),
    .POS_W      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wshade      (wshade),
    .target_valid(target_valid),
`ifdef SHADE_LIMIT_SW_EN
    .lim_top     (lim_top),
    .lim_bot     (lim_bot),
`endif
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .position    (position),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) assert (!(motor_up && motor_down))
      else $error("FAIL motor_exclusive: up=%0b down=%0b", motor_up, motor_down);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request (optionally a second one sampled at edge N+rk) and score the move
  // when its done pulse appears. Latency counted in edges after the request edge N.
  task automatic move_to(input logic [3:0] ws, input int rk, input logic [3:0] rv,
                         input int lat, input int nup, input int ndn);
    exp_t       e;
    exp_t       got_e;
    int         ups = 0;
    int         dns = 0;
    int         both = 0;
    int         trk_err = 0;
    int         done_k = -1;
    int         dir;
    int         d;
    logic       busy_at_done = 1'b1;
    logic [3:0] pos_at_done = 4'd0;
    e.pos = (rk > 0) ? int'(rv) : int'(ws);
    e.lat = lat;
    e.up  = nup;
    e.dn  = ndn;
    sb_q.push_back(e);
    dir = (int'(ws) > exp_position) ? 1 : ((int'(ws) < exp_position) ? -1 : 0);
    d   = (dir > 0) ? int'(ws) - exp_position : exp_position - int'(ws);
    wshade = ws;
    target_valid = 1'b1;
    for (int j = 0; j <= BUDGET && done_k < 0; j++) begin
      tick();
      if (j == 0) target_valid = 1'b0;
      if (rk > 0 && j == rk - 1) begin
        wshade = rv;
        target_valid = 1'b1;
      end
      if (rk > 0 && j == rk) target_valid = 1'b0;
      if (j >= 1) begin
        if (motor_up) ups++;
        if (motor_down) dns++;
        if (motor_up && motor_down) both++;
        if (rk == 0 && j <= 1 + 4 * d && int'(position) != exp_position + dir * ((j - 1) / 4))
          trk_err++;
        if (done) begin
          done_k       = j;
          busy_at_done = busy;
          pos_at_done  = position;
        end
      end
    end
    target_valid = 1'b0;
    got_e = sb_q.pop_front();
    if (done_k < 0) begin
      n_checks++;
      $display("FAIL move_timeout: no done within %0d cycles, wshade=%0d", BUDGET, ws);
    end else begin
      check("done_latency", done_k, got_e.lat);
      check("final_position", int'(pos_at_done), got_e.pos);
      check("motor_up_cycles", ups, got_e.up);
      check("motor_down_cycles", dns, got_e.dn);
      check("busy_at_done", int'(busy_at_done), 0);
      check("motors_both_on", both, 0);
      if (rk == 0) check("position_track_errors", trk_err, 0);
      tick();
      check("done_single_pulse", int'(done), 0);
    end
    exp_position = got_e.pos;
  endtask

  initial begin
    vecs[0] = '{4'd3,  14, 12, 0};
    vecs[1] = '{4'd3,  1,  0,  0};
    vecs[2] = '{4'd10, 30, 28, 0};
    vecs[3] = '{4'd4,  26, 0,  24};
    vecs[4] = '{4'd15, 46, 44, 0};
    vecs[5] = '{4'd15, 1,  0,  0};
    vecs[6] = '{4'd0,  62, 0,  60};
    vecs[7] = '{4'd10, 42, 40, 0};

    rst = 1'b1;
    repeat (2) tick();
    check("reset_position", int'(position), 0);
    check("reset_motor_up", int'(motor_up), 0);
    check("reset_motor_down", int'(motor_down), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) move_to(vecs[i].ws, 0, 4'd0, vecs[i].lat, vecs[i].up, vecs[i].dn);

    // Same-direction retarget 10 -> 14, then 15 at edge N+6: one uninterrupted climb.
    move_to(4'd14, 6, 4'd15, 22, 20, 0);

    // Reversal mid-step: 2 -> 8, retarget 0 at edge N+3; one dead cycle, then down.
    move_to(4'd2, 0, 4'd0, 54, 0, 52);
    move_to(4'd8, 3, 4'd0, 13, 2, 8);

    // Reset in the middle of a downward move.
    move_to(4'd6, 0, 4'd0, 26, 24, 0);
    wshade = 4'd0;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    repeat (7) tick();
    check("pre_reset_motor_down", int'(motor_down), 1);
    check("pre_reset_position", int'(position), 5);
    rst = 1'b1;
    tick();
    check("mid_reset_position", int'(position), 0);
    check("mid_reset_motor_up", int'(motor_up), 0);
    check("mid_reset_motor_down", int'(motor_down), 0);
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_done", int'(done), 0);
    rst = 1'b0;
    exp_position = 0;
    tick();
    move_to(4'd0, 0, 4'd0, 1, 0, 0);

`ifdef SHADE_LIMIT_SW_EN
    // Top end-stop hit at position 9 while heading for 15.
    move_to(4'd5, 0, 4'd0, 22, 20, 0);
    wshade = 4'd15;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    repeat (17) tick();
    check("lim_pre_position", int'(position), 9);
    lim_top = 1'b1;
    tick();
    lim_top = 1'b0;
    check("lim_position", int'(position), 15);
    check("lim_motor_up", int'(motor_up), 0);
    check("lim_busy", int'(busy), 1);
    check("lim_done_early", int'(done), 0);
    tick();
    check("lim_done", int'(done), 1);
    exp_position = 15;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
